// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU register read-out path.
package alu_pkg;

    typedef enum logic [1:0] {
        IDLE,
        HDR,
        DATA
    } reader_state_t;

    localparam logic [3:0]  SYNC_NIBBLE = 4'hA;
    localparam int unsigned BYTE_W      = 8;
    localparam int unsigned ERR_BIT     = 0;
    localparam int unsigned OVR_BIT     = 1;

    function automatic logic [BYTE_W-1:0] make_header(input logic [3:0] sync,
                                                      input logic       ovr,
                                                      input logic       err);
        logic [BYTE_W-1:0] h;
        h          = {sync, 4'b0000};
        h[OVR_BIT] = ovr;
        h[ERR_BIT] = err;
        return h;
    endfunction

endpackage

// File: rtl/alu_byte_mux.sv
// Combinational byte selector: returns byte[sel] of the captured result word.
module alu_byte_mux
    import alu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned CNT_W      = 1
) (
    input  logic [DATA_WIDTH-1:0] data,
    input  logic [CNT_W-1:0]      sel,
    output logic [BYTE_W-1:0]     byte_out
);

    localparam int unsigned NBYTES = DATA_WIDTH / BYTE_W;

    always_comb begin
        byte_out = '0;
        for (int unsigned k = 0; k < NBYTES; k++) begin
            if (sel == CNT_W'(k)) begin
                byte_out = data[k*BYTE_W +: BYTE_W];
            end
        end
    end

endmodule

// File: rtl/alu_result_reader.sv
// Captures the ALU result/error flags on res_load and streams them as a framed
// byte sequence (header, then result bytes MSB first) over a valid/ready link.
module alu_result_reader
    import alu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 16,
    parameter logic [3:0]  SYNC_NIBBLE = 4'hA
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  res_load,
    input  logic [DATA_WIDTH-1:0] res_data,
    input  logic                  res_error,
    input  logic                  clear_overrun,
    output logic                  tx_valid,
    output logic [BYTE_W-1:0]     tx_data,
    output logic                  tx_last,
    input  logic                  tx_ready,
    output logic                  busy,
    output logic                  overrun
);

    localparam int unsigned NBYTES   = DATA_WIDTH / BYTE_W;
    localparam int unsigned CNT_W    = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NBYTES - 1);

    reader_state_t         state;
    logic [CNT_W-1:0]      count;
    logic [DATA_WIDTH-1:0] cap_data;
    logic [CNT_W-1:0]      mux_sel;
    logic [BYTE_W-1:0]     mux_byte;
    logic                  accept;

    assign accept = tx_valid && tx_ready;

    // The mux looks one byte ahead so tx_data can be loaded as a register on accept.
    always_comb begin
        mux_sel = LAST_IDX;
        if (state == DATA) begin
            mux_sel = count - 1'b1;
        end
    end

    alu_byte_mux #(
        .DATA_WIDTH (DATA_WIDTH),
        .CNT_W      (CNT_W)
    ) u_byte_mux (
        .data     (cap_data),
        .sel      (mux_sel),
        .byte_out (mux_byte)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            count    <= '0;
            cap_data <= '0;
            tx_valid <= 1'b0;
            tx_data  <= '0;
            tx_last  <= 1'b0;
            busy     <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            if (res_load && (state != IDLE)) begin
                overrun <= 1'b1;
            end else if (clear_overrun) begin
                overrun <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (res_load) begin
                        cap_data <= res_data;
                        tx_data  <= make_header(SYNC_NIBBLE, overrun, res_error);
                        tx_valid <= 1'b1;
                        tx_last  <= 1'b0;
                        busy     <= 1'b1;
                        state    <= HDR;
                    end
                end
                HDR: begin
                    if (accept) begin
                        count   <= LAST_IDX;
                        tx_data <= mux_byte;
                        tx_last <= (NBYTES == 1);
                        state   <= DATA;
                    end
                end
                DATA: begin
                    if (accept) begin
                        if (count == '0) begin
                            tx_valid <= 1'b0;
                            tx_data  <= '0;
                            tx_last  <= 1'b0;
                            busy     <= 1'b0;
                            state    <= IDLE;
                        end else begin
                            count   <= count - 1'b1;
                            tx_data <= mux_byte;
                            tx_last <= (count == CNT_W'(1));
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_result_reader.sv
// Randomized and directed bench for alu_result_reader against a frame-queue reference model.
module tb_alu_result_reader;

    localparam int unsigned DW     = 16;
    localparam int unsigned NBYTES = DW / 8;

    logic          clock;
    logic          reset;
    logic          res_load;
    logic [DW-1:0] res_data;
    logic          res_error;
    logic          clear_overrun;
    logic          tx_valid;
    logic [7:0]    tx_data;
    logic          tx_last;
    logic          tx_ready;
    logic          busy;
    logic          overrun;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    // Reference model: bytes still owed by the current frame, plus the sticky flag.
    logic [7:0] exp_q[$];
    logic       m_ovr;

    alu_result_reader #(
        .DATA_WIDTH  (DW),
        .SYNC_NIBBLE (4'hA)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .res_load      (res_load),
        .res_data      (res_data),
        .res_error     (res_error),
        .clear_overrun (clear_overrun),
        .tx_valid      (tx_valid),
        .tx_data       (tx_data),
        .tx_last       (tx_last),
        .tx_ready      (tx_ready),
        .busy          (busy),
        .overrun       (overrun)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic check_outputs();
        logic exp_v;
        exp_v = (exp_q.size() != 0);
        check_eq("tx_valid", 32'(tx_valid), 32'(exp_v));
        check_eq("busy", 32'(busy), 32'(exp_v));
        check_eq("overrun", 32'(overrun), 32'(m_ovr));
        if (exp_v) begin
            check_eq("tx_data", 32'(tx_data), 32'(exp_q[0]));
            check_eq("tx_last", 32'(tx_last), 32'(exp_q.size() == 1));
        end else begin
            check_eq("tx_data_idle", 32'(tx_data), 32'h0);
            check_eq("tx_last_idle", 32'(tx_last), 32'h0);
        end
    endtask

    // One clock: check what the last edge produced, then drive inputs for the next edge.
    task automatic step(input logic ld, input logic [DW-1:0] d, input logic e,
                        input logic clr, input logic rdy);
        logic        was_busy;
        logic [7:0]  hdr;
        @(negedge clock);
        check_outputs();
        res_load      = ld;
        res_data      = d;
        res_error     = e;
        clear_overrun = clr;
        tx_ready      = rdy;

        was_busy = (exp_q.size() != 0);
        hdr      = 8'hA0 + (m_ovr ? 8'd2 : 8'd0) + (e ? 8'd1 : 8'd0);
        if (was_busy && rdy) begin
            void'(exp_q.pop_front());
        end
        if (ld && !was_busy) begin
            exp_q.push_back(hdr);
            for (int k = NBYTES - 1; k >= 0; k--) begin
                exp_q.push_back(8'((d >> (8 * k)) & 16'hFF));
            end
        end
        if (ld && was_busy) begin
            m_ovr = 1'b1;
        end else if (clr) begin
            m_ovr = 1'b0;
        end
    endtask

    task automatic idle(input int unsigned n, input logic rdy);
        for (int unsigned i = 0; i < n; i++) begin
            step(1'b0, 16'h0, 1'b0, 1'b0, rdy);
        end
    endtask

    task automatic do_reset();
        @(negedge clock);
        check_outputs();
        res_load      = 1'b0;
        clear_overrun = 1'b0;
        tx_ready      = 1'b1;
        #1 reset = 1'b0;
        #1;
        check_eq("rst_tx_valid", 32'(tx_valid), 32'h0);
        check_eq("rst_busy", 32'(busy), 32'h0);
        check_eq("rst_overrun", 32'(overrun), 32'h0);
        check_eq("rst_tx_data", 32'(tx_data), 32'h0);
        check_eq("rst_tx_last", 32'(tx_last), 32'h0);
        exp_q.delete();
        m_ovr = 1'b0;
        @(negedge clock);
        #2 reset = 1'b1;
    endtask

    initial begin
        reset         = 1'b0;
        res_load      = 1'b0;
        res_data      = '0;
        res_error     = 1'b0;
        clear_overrun = 1'b0;
        tx_ready      = 1'b0;
        m_ovr         = 1'b0;
        #1;
        check_eq("init_tx_valid", 32'(tx_valid), 32'h0);
        check_eq("init_busy", 32'(busy), 32'h0);
        check_eq("init_overrun", 32'(overrun), 32'h0);
        check_eq("init_tx_data", 32'(tx_data), 32'h0);
        #11 reset = 1'b1;

        // Single frame, ready held high
        step(1'b1, 16'h1234, 1'b0, 1'b0, 1'b1);
        idle(5, 1'b1);

        // Back-pressure: three stalled cycles before each accept
        step(1'b1, 16'hBEEF, 1'b1, 1'b0, 1'b0);
        for (int unsigned b = 0; b < 1 + NBYTES; b++) begin
            idle(2, 1'b0);
            step(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
            step(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
        end
        idle(3, 1'b1);

        // Overrun: second load two cycles after the first is dropped
        step(1'b1, 16'h0001, 1'b0, 1'b0, 1'b1);
        idle(1, 1'b1);
        step(1'b1, 16'h0002, 1'b0, 1'b0, 1'b1);
        idle(3, 1'b1);
        step(1'b1, 16'h0003, 1'b0, 1'b0, 1'b1);
        idle(4, 1'b1);
        // Clear together with an idle load: header still carries ovr, flag drops
        step(1'b1, 16'h0004, 1'b0, 1'b1, 1'b1);
        idle(4, 1'b1);

        // Set/clear race while busy: set wins
        step(1'b1, 16'h0005, 1'b0, 1'b0, 1'b1);
        step(1'b1, 16'h0006, 1'b0, 1'b1, 1'b1);
        idle(4, 1'b1);

        // Back-to-back: load in the cycle of the last accept, then one cycle later
        step(1'b1, 16'h0A0B, 1'b0, 1'b1, 1'b1);
        idle(1 + NBYTES - 1, 1'b1);
        step(1'b1, 16'h0C0D, 1'b1, 1'b0, 1'b1);
        step(1'b1, 16'h0E0F, 1'b0, 1'b0, 1'b1);
        idle(5, 1'b1);

        // Reset after the header accept of a frame
        step(1'b1, 16'h5678, 1'b0, 1'b0, 1'b1);
        step(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
        do_reset();
        idle(4, 1'b1);
        step(1'b1, 16'hCAFE, 1'b0, 1'b0, 1'b1);
        idle(4, 1'b1);

        // Randomized traffic
        for (int unsigned i = 0; i < 1500; i++) begin
            step(($urandom_range(0, 3) == 0), 16'($urandom), 1'($urandom),
                 ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) != 0));
        end
        idle(6, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
